// File: rtl/octree_fifo_rr_sched_if.sv
// Bundle between the round-robin scheduler, the per-lane FIFOs and the
// downstream consumer. The scheduler takes the master side.
interface octree_fifo_rr_sched_if #(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int QID_W = $clog2(NUM_Q);

    logic [NUM_Q-1:0]            q_empty;
    logic [NUM_Q-1:0]            q_rd_en;
    logic [NUM_Q*DATA_WIDTH-1:0] q_rdata;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [QID_W-1:0]            out_qid;

    modport master (
        input  q_empty, q_rdata, out_ready,
        output q_rd_en, out_valid, out_data, out_qid
    );

    modport slave (
        output q_empty, q_rdata, out_ready,
        input  q_rd_en, out_valid, out_data, out_qid
    );
endinterface

// File: rtl/octree_fifo_rr_sched.sv
// Round-robin drain of NUM_Q traversal-lane FIFOs onto one valid/ready port.
// Each grant reads a FIFO, captures its registered rdata one cycle later and
// presents it tagged with the source queue id. Bursts of up to MAX_BURST
// words stay on one queue before the pointer rotates past it.
//
//   state | meaning
//   IDLE  | no word in flight; issue a read as soon as a candidate exists
//   CAPT  | read issued last cycle; FIFO rdata is valid now, capture it
//   HOLD  | word presented on out_*; wait for out_ready, then chain next read
module octree_fifo_rr_sched #(
    parameter int NUM_Q      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sched_en,
    output logic                         busy,
    octree_fifo_rr_sched_if.master       bus
);
    localparam int QID_W = $clog2(NUM_Q);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    logic [QID_W-1:0]        rr_ptr_q;
    logic [QID_W-1:0]        sel_q;
    logic [BC_W-1:0]         burst_cnt_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [QID_W-1:0]        out_qid_q;

    logic                    cand;
    logic                    cont;
    logic [QID_W-1:0]        ptr_rot;
    logic [QID_W-1:0]        pick_idle;
    logic [QID_W-1:0]        pick_rot;
    logic                    rd_fire;
    logic                    rd_new;
    logic [QID_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   cap_word;

    // First non-empty queue at or after ptr, wrapping modulo NUM_Q.
    function automatic logic [QID_W-1:0] pick_from(
        input logic [QID_W-1:0] ptr,
        input logic [NUM_Q-1:0] empty
    );
        logic [QID_W-1:0] idx;
        logic [QID_W-1:0] res;
        logic             found;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_Q; k++) begin
            idx = ptr + QID_W'(k);
            if (!found && !empty[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Read-issue decision; the rd_en pulse is combinational so the FIFO
    // sees it in the same cycle the FSM commits to the grant.
    always_comb begin
        cand      = sched_en && (|(~bus.q_empty));
        ptr_rot   = sel_q + QID_W'(1);
        pick_idle = pick_from(rr_ptr_q, bus.q_empty);
        pick_rot  = pick_from(ptr_rot, bus.q_empty);
        cont      = sched_en && !bus.q_empty[sel_q]
                    && (burst_cnt_q < BC_W'(MAX_BURST));
        cap_word  = bus.q_rdata[int'(sel_q) * DATA_WIDTH +: DATA_WIDTH];
        rd_fire   = 1'b0;
        rd_new    = 1'b0;
        rd_idx    = sel_q;
        case (state_q)
            IDLE: begin
                if (cand) begin
                    rd_fire = 1'b1;
                    rd_new  = 1'b1;
                    rd_idx  = pick_idle;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (cont) begin
                        rd_fire = 1'b1;
                        rd_idx  = sel_q;
                    end else if (cand) begin
                        rd_fire = 1'b1;
                        rd_new  = 1'b1;
                        rd_idx  = pick_rot;
                    end
                end
            end
            default: ;
        endcase
    end

    // Scheduler FSM with registered output word, tag and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            sel_q       <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_qid_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_fire) begin
                        sel_q       <= rd_idx;
                        burst_cnt_q <= BC_W'(1);
                        state_q     <= CAPT;
                    end
                end
                CAPT: begin
                    out_data_q  <= cap_word;
                    out_qid_q   <= sel_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        // Burst over: rotate past the queue just served,
                        // whether or not another queue is picked now.
                        if (!cont) begin
                            rr_ptr_q <= ptr_rot;
                        end
                        if (rd_fire) begin
                            sel_q       <= rd_idx;
                            burst_cnt_q <= rd_new ? BC_W'(1)
                                                  : burst_cnt_q + BC_W'(1);
                            state_q     <= CAPT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q_rd_en   = rd_fire ? ({{(NUM_Q-1){1'b0}}, 1'b1} << rd_idx) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_qid   = out_qid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_octree_fifo_rr_sched.sv
// Bench for octree_fifo_rr_sched: behavioural FIFOs plus a transaction-level
// round-robin model checked every cycle, and literal checks per scenario.
module tb_octree_fifo_rr_sched;
    localparam int NQ    = 4;
    localparam int DW    = 32;
    localparam int MB    = 4;
    localparam int QW    = $clog2(NQ);
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sched_en = 1'b0;
    logic busy;

    octree_fifo_rr_sched_if #(.NUM_Q(NQ), .DATA_WIDTH(DW)) bus ();

    octree_fifo_rr_sched #(.NUM_Q(NQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_en (sched_en),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // FIFO models: registered rdata, shared reset flushes contents.
    logic [DW-1:0] mem [NQ][DEPTH];
    int            wrptr [NQ];
    int            rdptr [NQ];
    logic [DW-1:0] rdata_reg [NQ];
    logic [NQ-1:0] rd_en_s = '0;

    for (genvar g = 0; g < NQ; g++) begin : g_fifo
        assign bus.q_empty[g]           = (wrptr[g] == rdptr[g]);
        assign bus.q_rdata[g*DW +: DW]  = rdata_reg[g];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                rdptr[q]     <= wrptr[q];
                rdata_reg[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (rd_en_s[q]) begin
                    rdata_reg[q] <= mem[q][rdptr[q] % DEPTH];
                    rdptr[q]     <= rdptr[q] + 1;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    // Model state
    int            m_ptr, m_sel, m_burst, m_age;
    bit            m_has;
    logic [QW-1:0] m_qid;
    logic [DW-1:0] m_data;
    int            cyc = 0;

    // Accepted-word log
    int            acc_n = 0;
    int            acc_qid [64];
    logic [DW-1:0] acc_data [64];
    int            acc_cyc [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lvl(input int q);
        return wrptr[q] - rdptr[q];
    endfunction

    function automatic int pick_q(input int ptr);
        for (int k = 0; k < NQ; k++) begin
            if (lvl((ptr + k) % NQ) > 0) return (ptr + k) % NQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_sel = 0; m_burst = 0; m_age = 0; m_has = 0;
        m_qid = '0; m_data = '0;
    endtask

    // Per-cycle comparison against the transaction model.
    task automatic step();
        logic [NQ-1:0] rd;
        int            grant;
        bit            exp_ov, accept;
        cyc++;
        rd      = bus.q_rd_en;
        rd_en_s = rd;
        if (!rst_n) begin
            chk("reset_outputs", 64'({rd, bus.out_valid, busy, bus.out_qid, bus.out_data}), 64'd0);
            model_reset();
            return;
        end
        if (m_has) m_age++;
        chk("busy", 64'(busy), 64'(m_has));
        exp_ov = m_has && (m_age >= 2);
        chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov) chk("out_word", 64'({bus.out_qid, bus.out_data}), 64'({m_qid, m_data}));
        accept = exp_ov && bus.out_ready;
        grant  = -1;
        if (accept) begin
            if (acc_n < 64) begin
                acc_qid[acc_n]  = int'(m_qid);
                acc_data[acc_n] = m_data;
                acc_cyc[acc_n]  = cyc;
                acc_n++;
            end
            m_has = 0;
            if (sched_en && lvl(m_sel) > 0 && m_burst < MB) begin
                grant = m_sel;
                m_burst++;
            end else begin
                m_ptr = (m_sel + 1) % NQ;
                if (sched_en) grant = pick_q(m_ptr);
                m_burst = 1;
            end
        end else if (!m_has) begin
            if (sched_en) grant = pick_q(m_ptr);
            m_burst = 1;
        end
        chk("q_rd_en", 64'(rd), (grant >= 0) ? (64'd1 << grant) : 64'd0);
        if (grant >= 0) begin
            m_has  = 1;
            m_age  = 0;
            m_sel  = grant;
            m_qid  = QW'(grant);
            m_data = mem[grant][rdptr[grant] % DEPTH];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        acc_n = 0;
    endtask

    task automatic load(input int q, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[q][wrptr[q] % DEPTH] = base + DW'(k);
            wrptr[q]++;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int  k;
        bit  done;
        done = 0;
        for (k = 0; k < budget && !done; k++) begin
            tick();
            if (!busy && !bus.out_valid && pick_q(0) < 0) done = 1;
        end
        chk({name, "_drain_in_budget"}, 64'(done), 64'd1);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (bus.out_valid) seen = 1;
        end
        chk({name, "_valid_in_budget"}, 64'(seen), 64'd1);
    endtask

    int            exp_order2 [24] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
    int            per_q [NQ];
    logic [DW-1:0] h_data;
    logic [QW-1:0] h_qid;

    initial begin
        bus.out_ready = 1'b0;
        model_reset();
        fork
            forever begin
                @(negedge clk);
                step();
            end
        join_none

        // 1: q0 only, three words back to back
        do_reset();
        sched_en = 1'b1;
        bus.out_ready = 1'b1;
        load(0, 3, 32'hA000_0000);
        wait_drain("s1", 60);
        chk("s1_count", 64'(acc_n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("s1_data", 64'(acc_data[i]), 64'(32'hA000_0000 + i));
            chk("s1_qid", 64'(acc_qid[i]), 64'd0);
        end
        chk("s1_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
        chk("s1_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
        chk("s1_idle_busy", 64'(busy), 64'd0);

        // 2: all four queues, six words each, bursts of four then two
        do_reset();
        for (int q = 0; q < NQ; q++) load(q, 6, 32'hB000_0000 + 32'(q << 8));
        wait_drain("s2", 150);
        chk("s2_count", 64'(acc_n), 64'd24);
        per_q = '{0, 0, 0, 0};
        for (int i = 0; i < 24; i++) begin
            chk("s2_qid_order", 64'(acc_qid[i]), 64'(exp_order2[i]));
            chk("s2_data", 64'(acc_data[i]),
                64'(32'hB000_0000 + 32'(exp_order2[i] << 8) + 32'(per_q[exp_order2[i]])));
            per_q[exp_order2[i]]++;
        end

        // 3: stall a q2 word for five cycles
        do_reset();
        bus.out_ready = 1'b0;
        load(2, 3, 32'hC000_0000);
        wait_valid("s3", 20);
        h_data = bus.out_data;
        h_qid  = bus.out_qid;
        chk("s3_hold_qid", 64'(h_qid), 64'd2);
        chk("s3_hold_data", 64'(h_data), 64'(32'hC000_0000));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_stable_data", 64'(bus.out_data), 64'(32'hC000_0000));
            chk("s3_stable_qid", 64'(bus.out_qid), 64'd2);
            chk("s3_no_read", 64'(bus.q_rd_en), 64'd0);
            chk("s3_still_valid", 64'(bus.out_valid), 64'd1);
        end
        chk("s3_level", 64'(lvl(2)), 64'd2);
        bus.out_ready = 1'b1;
        wait_drain("s3", 40);
        chk("s3_count", 64'(acc_n), 64'd3);
        chk("s3_gap_after_release", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);

        // 4: pointer at 3, only q1 loaded -> wrap to q1, pointer then 2
        do_reset();
        load(2, 1, 32'hD000_0000);
        wait_drain("s4a", 30);
        load(1, 1, 32'hD000_0001);
        wait_drain("s4b", 30);
        load(0, 1, 32'hD000_0002);
        load(2, 1, 32'hD000_0003);
        wait_drain("s4c", 30);
        chk("s4_count", 64'(acc_n), 64'd4);
        chk("s4_q1_wrap", 64'(acc_qid[1]), 64'd1);
        chk("s4_after_q1", 64'(acc_qid[2]), 64'd2);
        chk("s4_last", 64'(acc_qid[3]), 64'd0);

        // 5: reset while capturing mid-burst
        do_reset();
        load(0, 4, 32'hE000_0000);
        wait_valid("s5", 20);
        tick();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("s5_rst_rd_en", 64'(bus.q_rd_en), 64'd0);
        chk("s5_rst_busy", 64'(busy), 64'd0);
        chk("s5_rst_data", 64'(bus.out_data), 64'd0);
        chk("s5_rst_qid", 64'(bus.out_qid), 64'd0);
        tick();
        rst_n = 1'b1;
        acc_n = 0;
        load(1, 1, 32'hE100_0000);
        load(0, 1, 32'hE000_0010);
        wait_drain("s5", 30);
        chk("s5_count", 64'(acc_n), 64'd2);
        chk("s5_restart_q0", 64'(acc_qid[0]), 64'd0);
        chk("s5_then_q1", 64'(acc_qid[1]), 64'd1);

        // 6: sched_en dropped while holding a q0 word
        do_reset();
        bus.out_ready = 1'b0;
        load(0, 4, 32'hF000_0000);
        wait_valid("s6", 20);
        chk("s6_level_hold", 64'(lvl(0)), 64'd3);
        sched_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("s6_delivered", 64'(acc_n), 64'd1);
        chk("s6_level_after", 64'(lvl(0)), 64'd3);
        chk("s6_idle", 64'(busy), 64'd0);
        load(1, 1, 32'hF100_0000);
        sched_en = 1'b1;
        wait_drain("s6", 40);
        chk("s6_count", 64'(acc_n), 64'd5);
        chk("s6_resume_q1", 64'(acc_qid[1]), 64'd1);
        chk("s6_resume_data", 64'(acc_data[1]), 64'(32'hF100_0000));
        chk("s6_back_to_q0", 64'(acc_qid[2]), 64'd0);
        chk("s6_q0_data", 64'(acc_data[4]), 64'(32'hF000_0003));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/octree_fifo_rr_sched.md
Name: octree_fifo_rr_sched

Overview:
Round-robin read scheduler that drains NUM_Q synchronous FIFOs (one per octree traversal lane) onto a single valid/ready consumer port. It drives each FIFO's rd_en and captures that FIFO's registered rdata one cycle later. Each output word is tagged with its source queue id. It sits between the per-lane fifo_sync instances and the shared Gaussian-fetch/anchor-decode stage.

Parameters:
NUM_Q, 4, number of source FIFOs (>=2, power of two)
DATA_WIDTH, 32, word width of each FIFO and of the output
MAX_BURST, 4, max consecutive words taken from one queue before rotating (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
sched_en  input  1  scheduling enable; when low no new FIFO reads are issued
q_empty  input  NUM_Q  empty flags from the FIFOs, bit i = queue i
q_rd_en  output  NUM_Q  read enables to the FIFOs, at most one bit high per cycle
q_rdata  input  NUM_Q*DATA_WIDTH  FIFO read data, queue i at [i*DATA_WIDTH +: DATA_WIDTH], valid the cycle after its rd_en
out_valid  output  1  output word valid
out_ready  input  1  consumer accepts the word
out_data  output  DATA_WIDTH  output word
out_qid  output  $clog2(NUM_Q)  source queue of out_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state=IDLE, rr_ptr=0, burst_cnt=0, sel=0, q_rd_en=0, out_valid=0, out_data=0, out_qid=0, busy=0. A word being captured or held is dropped. The FIFOs share rst_n.
- Pick function: the first queue i with q_empty[i]==0, scanning from rr_ptr upward with wrap modulo NUM_Q. "Candidate exists" means sched_en=1 and at least one queue is non-empty.
- States: IDLE, CAPT, HOLD.
- IDLE: if a candidate exists, assert q_rd_en[pick] combinationally this cycle, sel<=pick, burst_cnt<=1, go to CAPT. Otherwise stay.
- CAPT (1 cycle): out_data<=q_rdata[sel], out_qid<=sel, out_valid<=1, go to HOLD. q_rd_en=0.
- HOLD: out_valid=1. out_data and out_qid stay stable until out_ready=1.
  - out_ready=0: stay in HOLD, no reads issued.
  - out_ready=1, continue burst (sched_en=1, q_empty[sel]=0, burst_cnt<MAX_BURST): assert q_rd_en[sel] in the same cycle, burst_cnt++, go to CAPT. out_valid is 0 in the CAPT cycle.
  - out_ready=1, otherwise: the burst ends and rr_ptr<=(sel+1) mod NUM_Q. If another candidate exists (pick evaluated using the new rr_ptr value, computed combinationally), issue rd_en to it, sel<=pick, burst_cnt<=1, go to CAPT. Otherwise go to IDLE with out_valid<=0.
- Throughput: one word per 2 cycles at best. Latency from rd_en to out_valid is 2 cycles.
- Never assert rd_en to an empty queue. Never assert more than one q_rd_en bit. Never issue a read while out_valid=1 and out_ready=0.
- A queue that empties mid-burst ends the burst early and rotates rr_ptr past it.
- sched_en dropping mid-burst: the word being captured or held is still delivered, then the block goes to IDLE. rr_ptr advances past sel.
- out_qid width is $clog2(NUM_Q). rr_ptr wraps naturally at the power-of-two NUM_Q.

Test Plan:
- Only q0 loaded with 3 words (A,B,C), out_ready=1 -> out_data A,B,C on every 2nd cycle, out_qid=0, then IDLE with busy=0 and rr_ptr=1.
- All 4 queues loaded with 6 words each, MAX_BURST=4, out_ready=1 -> qid order 0x4, 1x4, 2x4, 3x4, 0x2, 1x2, 2x2, 3x2. 24 words total, none duplicated or lost.
- Hold word from q2 with out_ready=0 for 5 cycles -> out_data/out_qid stable, q_rd_en=0 throughout, FIFO level unchanged. On release the next word follows 2 cycles later.
- rr_ptr=3, only q1 non-empty (1 word) -> pick wraps to q1 (q_rd_en=4'b0010). After delivery rr_ptr=2.
- Assert rst_n low for 1 cycle while in CAPT mid-burst -> all outputs 0 immediately and state=IDLE. After release, scheduling restarts from q0.
- sched_en deasserted during HOLD with q0 still holding 3 words -> held word is delivered, then no further q_rd_en. Reasserting sched_en resumes at q1 if it is non-empty, else at q0.
